hazard_control_unit: RTL and testbench

Sequential, parametrised hazard controller for the in-order RISC-V pipeline, sitting between decode and the pipeline-register enables. Extends plain load-use detection with configurable load-to-use latency, multi-cycle stalls counted in a small FSM, a freeze for a multi-cycle MDU (mul/div), x0 and operand-usage qualification, and a saturating stall-cycle performance counter. Drives PC/IF-ID/ID-EX enables, bubbles and the IF/ID branch flush.

---
 rtl/hazard_pkg.sv | 26 ++
 rtl/hazard_match.sv | 19 +
 rtl/hazard_control_unit.sv | 127 ++++++++++++
 tb/tb_hazard_control_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {RUN, LD_STALL, MDU_STALL} state_t;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_write;
    logic id_ex_bubble;
    logic ex_mem_bubble;
    logic if_id_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_DEFAULT = '{pc_write: 1'b1, if_id_write: 1'b1, id_ex_write: 1'b1,
                                     id_ex_bubble: 1'b0, ex_mem_bubble: 1'b0, if_id_flush: 1'b0};
  localparam ctrl_t CTRL_STALL   = '{pc_write: 1'b0, if_id_write: 1'b0, id_ex_write: 1'b1,
                                     id_ex_bubble: 1'b1, ex_mem_bubble: 1'b0, if_id_flush: 1'b0};
  localparam ctrl_t CTRL_FREEZE  = '{pc_write: 1'b0, if_id_write: 1'b0, id_ex_write: 1'b0,
                                     id_ex_bubble: 1'b0, ex_mem_bubble: 1'b1, if_id_flush: 1'b0};

  function automatic bit load_stall_legal(input int unsigned n);
    return (n >= 1) && (n <= 3);
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Load-use match for one pipeline stage: a load to a non-x0 register read by ID.
module hazard_match #(
  parameter int unsigned ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic              rs1_used,
  input  logic              rs2_used,
  input  logic [ADDR_W-1:0] rd,
  input  logic              mem_read,
  output logic              hit
);

  always_comb begin
    hit = mem_read && (rd != '0) &&
          ((rs1_used && (rs1 == rd)) || (rs2_used && (rs2 == rd)));
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Load-use / MDU hazard controller driving pipeline-register enables, bubbles and branch flush.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned LOAD_STALL = 1,
  parameter bit          MDU_EN     = 1'b1,
  parameter int unsigned CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs1D,
  input  logic [ADDR_W-1:0] rs2D,
  input  logic              rs1_usedD,
  input  logic              rs2_usedD,
  input  logic [ADDR_W-1:0] ID_EX_rdE,
  input  logic              ID_EX_MemReadEn,
  input  logic [ADDR_W-1:0] EX_MEM_rdM,
  input  logic              EX_MEM_MemReadEn,
  input  logic              mdu_startE,
  input  logic              mdu_done,
  input  logic              Branch_Detected,
  output logic              PCWrite,
  output logic              IF_IDWrite,
  output logic              ID_EXWrite,
  output logic              ID_EXBubble,
  output logic              EX_MEMBubble,
  output logic              IF_IDFlush,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int unsigned CW = $clog2(LOAD_STALL + 1);

  if (!load_stall_legal(LOAD_STALL)) begin : g_bad_load_stall
    $error("hazard_control_unit: LOAD_STALL must be 1..3");
  end

  logic hit_ex, hit_mem;

  hazard_match #(.ADDR_W(ADDR_W)) u_match_ex (
    .rs1(rs1D), .rs2(rs2D), .rs1_used(rs1_usedD), .rs2_used(rs2_usedD),
    .rd(ID_EX_rdE), .mem_read(ID_EX_MemReadEn), .hit(hit_ex)
  );

  hazard_match #(.ADDR_W(ADDR_W)) u_match_mem (
    .rs1(rs1D), .rs2(rs2D), .rs1_used(rs1_usedD), .rs2_used(rs2_usedD),
    .rd(EX_MEM_rdM), .mem_read(EX_MEM_MemReadEn), .hit(hit_mem)
  );

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  ctrl_t         ctrl;
  logic          run_eval, allow_mdu;

  // MDU_STALL on mdu_done falls through to the RUN decision with the MDU start masked.
  always_comb begin
    ctrl      = CTRL_DEFAULT;
    state_nxt = state;
    cnt_nxt   = cnt;
    run_eval  = 1'b0;
    allow_mdu = 1'b0;

    unique case (state)
      RUN: begin
        run_eval  = 1'b1;
        allow_mdu = 1'b1;
      end
      LD_STALL: begin
        ctrl    = CTRL_STALL;
        cnt_nxt = cnt - CW'(1);
        if (cnt <= CW'(1)) state_nxt = RUN;
      end
      MDU_STALL: begin
        if (MDU_EN && !mdu_done) begin
          ctrl = CTRL_FREEZE;
        end else begin
          run_eval  = 1'b1;
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase

    if (run_eval) begin
      if (allow_mdu && MDU_EN && mdu_startE && !mdu_done) begin
        ctrl      = CTRL_FREEZE;
        state_nxt = MDU_STALL;
      end else if (hit_ex) begin
        ctrl = CTRL_STALL;
        if (LOAD_STALL > 1) begin
          cnt_nxt   = CW'(LOAD_STALL - 1);
          state_nxt = LD_STALL;
        end
      end else if ((LOAD_STALL >= 2) && hit_mem) begin
        ctrl = CTRL_STALL;
        if (LOAD_STALL > 2) begin
          cnt_nxt   = CW'(LOAD_STALL - 2);
          state_nxt = LD_STALL;
        end
      end else if (Branch_Detected) begin
        ctrl.if_id_flush = 1'b1;
      end
    end

    if (!rst_n) ctrl = CTRL_DEFAULT;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= RUN;
      cnt          <= '0;
      stall_cycles <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (!ctrl.pc_write && (stall_cycles != '1)) stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

  assign PCWrite      = ctrl.pc_write;
  assign IF_IDWrite   = ctrl.if_id_write;
  assign ID_EXWrite   = ctrl.id_ex_write;
  assign ID_EXBubble  = ctrl.id_ex_bubble;
  assign EX_MEMBubble = ctrl.ex_mem_bubble;
  assign IF_IDFlush   = ctrl.if_id_flush;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: LOAD_STALL=1 (CNT_W=4) and LOAD_STALL=3 instances on shared inputs.
module tb_hazard_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1D, rs2D, ID_EX_rdE, EX_MEM_rdM;
  logic       rs1_usedD, rs2_usedD, ID_EX_MemReadEn, EX_MEM_MemReadEn;
  logic       mdu_startE, mdu_done, Branch_Detected;

  logic        pc1, ifid1, idex1, idb1, exb1, fl1;
  logic [3:0]  cnt1;
  logic        pc3, ifid3, idex3, idb3, exb3, fl3;
  logic [31:0] cnt3;

  logic [5:0] ctrl1, ctrl3;
  assign ctrl1 = {pc1, ifid1, idex1, idb1, exb1, fl1};
  assign ctrl3 = {pc3, ifid3, idex3, idb3, exb3, fl3};

  localparam logic [5:0] C_DEF = 6'b111000;
  localparam logic [5:0] C_STL = 6'b001100;
  localparam logic [5:0] C_FRZ = 6'b000010;
  localparam logic [5:0] C_FLS = 6'b111001;

  hazard_control_unit #(.ADDR_W(5), .LOAD_STALL(1), .MDU_EN(1'b1), .CNT_W(4)) u_ls1 (
    .clk(clk), .rst_n(rst_n), .rs1D(rs1D), .rs2D(rs2D), .rs1_usedD(rs1_usedD), .rs2_usedD(rs2_usedD),
    .ID_EX_rdE(ID_EX_rdE), .ID_EX_MemReadEn(ID_EX_MemReadEn), .EX_MEM_rdM(EX_MEM_rdM),
    .EX_MEM_MemReadEn(EX_MEM_MemReadEn), .mdu_startE(mdu_startE), .mdu_done(mdu_done),
    .Branch_Detected(Branch_Detected), .PCWrite(pc1), .IF_IDWrite(ifid1), .ID_EXWrite(idex1),
    .ID_EXBubble(idb1), .EX_MEMBubble(exb1), .IF_IDFlush(fl1), .stall_cycles(cnt1)
  );

  hazard_control_unit #(.ADDR_W(5), .LOAD_STALL(3), .MDU_EN(1'b1), .CNT_W(32)) u_ls3 (
    .clk(clk), .rst_n(rst_n), .rs1D(rs1D), .rs2D(rs2D), .rs1_usedD(rs1_usedD), .rs2_usedD(rs2_usedD),
    .ID_EX_rdE(ID_EX_rdE), .ID_EX_MemReadEn(ID_EX_MemReadEn), .EX_MEM_rdM(EX_MEM_rdM),
    .EX_MEM_MemReadEn(EX_MEM_MemReadEn), .mdu_startE(mdu_startE), .mdu_done(mdu_done),
    .Branch_Detected(Branch_Detected), .PCWrite(pc3), .IF_IDWrite(ifid3), .ID_EXWrite(idex3),
    .ID_EXBubble(idb3), .EX_MEMBubble(exb3), .IF_IDFlush(fl3), .stall_cycles(cnt3)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rdE;
    logic       mrE;
    logic [4:0] rdM;
    logic       mrM;
    logic       st, dn, br;
    logic [5:0] exp_ctrl;
    logic [3:0] exp_cnt;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    rs1D = '0; rs2D = '0; rs1_usedD = 1'b0; rs2_usedD = 1'b0;
    ID_EX_rdE = '0; ID_EX_MemReadEn = 1'b0; EX_MEM_rdM = '0; EX_MEM_MemReadEn = 1'b0;
    mdu_startE = 1'b0; mdu_done = 1'b0; Branch_Detected = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    rs1D = v.rs1; rs2D = v.rs2; rs1_usedD = v.u1; rs2_usedD = v.u2;
    ID_EX_rdE = v.rdE; ID_EX_MemReadEn = v.mrE; EX_MEM_rdM = v.rdM; EX_MEM_MemReadEn = v.mrM;
    mdu_startE = v.st; mdu_done = v.dn; Branch_Detected = v.br;
  endtask

  task automatic ex_hit(input logic [4:0] r);
    clear_in();
    rs1D = r; rs1_usedD = 1'b1; ID_EX_rdE = r; ID_EX_MemReadEn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           rs1   rs2   u1    u2    rdE   mrE   rdM   mrM   st    dn    br    ctrl   cnt(before edge)
    tbl[0]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_DEF, 4'd0};
    tbl[1]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_STL, 4'd0};
    tbl[2]  = '{5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_DEF, 4'd1};
    tbl[3]  = '{5'd3, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_DEF, 4'd1};
    tbl[4]  = '{5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_STL, 4'd1};
    tbl[5]  = '{5'd6, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, C_DEF, 4'd2};
    tbl[6]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, C_FLS, 4'd2};
    tbl[7]  = '{5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, C_STL, 4'd2};
    tbl[8]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, C_DEF, 4'd3};
    tbl[9]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, C_FLS, 4'd3};
    tbl[10] = '{5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_DEF, 4'd3};

    // Reset with a live hazard on the inputs: outputs must stay at defaults.
    rst_n = 1'b0;
    ex_hit(5'd5);
    tick();
    tick();
    #2;
    chk("reset_ctrl_ls1", {26'd0, ctrl1}, {26'd0, C_DEF});
    chk("reset_ctrl_ls3", {26'd0, ctrl3}, {26'd0, C_DEF});
    chk("reset_cnt_ls1", {28'd0, cnt1}, 32'd0);
    chk("reset_cnt_ls3", cnt3, 32'd0);
    rst_n = 1'b1;
    clear_in();
    tick();

    for (int i = 0; i < 11; i++) begin
      apply(tbl[i]);
      #2;
      chk($sformatf("tbl%0d_ctrl", i), {26'd0, ctrl1}, {26'd0, tbl[i].exp_ctrl});
      chk($sformatf("tbl%0d_cnt", i), {28'd0, cnt1}, {28'd0, tbl[i].exp_cnt});
      tick();
    end

    // LOAD_STALL=3: EX-distance hit with a branch pending.
    clear_in();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    ex_hit(5'd7);
    Branch_Detected = 1'b1;
    #2; chk("ls3_ex_c0", {26'd0, ctrl3}, {26'd0, C_STL});
    tick();
    ID_EX_MemReadEn = 1'b0;
    #2; chk("ls3_ex_c1", {26'd0, ctrl3}, {26'd0, C_STL});
    tick();
    #2; chk("ls3_ex_c2", {26'd0, ctrl3}, {26'd0, C_STL});
    tick();
    #2; chk("ls3_ex_c3_flush", {26'd0, ctrl3}, {26'd0, C_FLS});
    chk("ls3_ex_cnt", cnt3, 32'd3);
    tick();

    // LOAD_STALL=3: MEM-distance hit -> two stall cycles.
    clear_in();
    rs2D = 5'd6; rs2_usedD = 1'b1; EX_MEM_rdM = 5'd6; EX_MEM_MemReadEn = 1'b1;
    #2; chk("ls3_mem_c0", {26'd0, ctrl3}, {26'd0, C_STL});
    chk("ls1_mem_ignored", {26'd0, ctrl1}, {26'd0, C_DEF});
    tick();
    clear_in();
    #2; chk("ls3_mem_c1", {26'd0, ctrl3}, {26'd0, C_STL});
    tick();
    #2; chk("ls3_mem_c2", {26'd0, ctrl3}, {26'd0, C_DEF});
    chk("ls3_mem_cnt", cnt3, 32'd5);
    tick();

    // MDU: start, done four cycles later.
    mdu_startE = 1'b1;
    #2; chk("mdu_c0_ls3", {26'd0, ctrl3}, {26'd0, C_FRZ});
    chk("mdu_c0_ls1", {26'd0, ctrl1}, {26'd0, C_FRZ});
    tick();
    mdu_startE = 1'b0;
    for (int c = 1; c < 4; c++) begin
      #2; chk($sformatf("mdu_c%0d", c), {26'd0, ctrl3}, {26'd0, C_FRZ});
      tick();
    end
    mdu_done = 1'b1;
    #2; chk("mdu_done_release", {26'd0, ctrl3}, {26'd0, C_DEF});
    tick();
    mdu_done = 1'b0;
    #2; chk("mdu_after", {26'd0, ctrl3}, {26'd0, C_DEF});
    chk("mdu_cnt", cnt3, 32'd9);
    tick();

    // Reset in the second cycle of a LOAD_STALL=3 stall.
    ex_hit(5'd7);
    #2; chk("rst_mid_c0", {26'd0, ctrl3}, {26'd0, C_STL});
    tick();
    clear_in();
    rst_n = 1'b0;
    #2; chk("rst_mid_c1", {26'd0, ctrl3}, {26'd0, C_DEF});
    tick();
    rst_n = 1'b1;
    #2; chk("rst_mid_c2", {26'd0, ctrl3}, {26'd0, C_DEF});
    chk("rst_mid_cnt", cnt3, 32'd0);
    tick();
    #2; chk("rst_mid_c3", {26'd0, ctrl3}, {26'd0, C_DEF});
    tick();

    // Saturation of the 4-bit counter on the LOAD_STALL=1 instance.
    ex_hit(5'd5);
    for (int i = 0; i < 20; i++) begin
      #2;
      if (i == 14) chk("sat_cnt14", {28'd0, cnt1}, 32'd14);
      if (i == 15) chk("sat_cnt15", {28'd0, cnt1}, 32'd15);
      tick();
    end
    #2;
    chk("sat_ctrl", {26'd0, ctrl1}, {26'd0, C_STL});
    chk("sat_hold", {28'd0, cnt1}, 32'd15);
    clear_in();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
